// File: rtl/lock_pkg.sv
// Shared state encodings and 5-bit display symbols for the keypad lock and its segment driver.
package lock_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SYM_W   = 5;
    localparam int unsigned WORD_W  = 4 * SYM_W;

    typedef enum logic [STATE_W-1:0] {
        ST_LOCKED     = 3'd0,
        ST_ENTER_L    = 3'd1,
        ST_UNLOCKED   = 3'd2,
        ST_ENTER_U    = 3'd3,
        ST_NEW_PW     = 3'd4,
        ST_CONFIRM_PW = 3'd5,
        ST_LOCKOUT    = 3'd6
    } lock_state_e;

    // Symbols 0x00..0x0F are hex digits; C, d and E reuse their hex glyphs.
    localparam logic [SYM_W-1:0] SYM_C     = 5'h0C;
    localparam logic [SYM_W-1:0] SYM_D     = 5'h0D;
    localparam logic [SYM_W-1:0] SYM_E     = 5'h0E;
    localparam logic [SYM_W-1:0] SYM_L     = 5'h10;
    localparam logic [SYM_W-1:0] SYM_S     = 5'h11;
    localparam logic [SYM_W-1:0] SYM_O     = 5'h12;
    localparam logic [SYM_W-1:0] SYM_P     = 5'h13;
    localparam logic [SYM_W-1:0] SYM_N     = 5'h14;
    localparam logic [SYM_W-1:0] SYM_TIRE  = 5'h15;
    localparam logic [SYM_W-1:0] SYM_BLANK = 5'h1F;

    // Four-position status word shown in the non-entry states.
    function automatic logic [WORD_W-1:0] status_word(input lock_state_e st);
        logic [WORD_W-1:0] w;
        w = {4{SYM_BLANK}};
        case (st)
            ST_LOCKED:   w = {SYM_C, SYM_L, SYM_S, SYM_D};
            ST_UNLOCKED: w = {SYM_O, SYM_P, SYM_E, SYM_N};
            ST_LOCKOUT:  w = {4{SYM_TIRE}};
            default:     w = {4{SYM_BLANK}};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lock_cycle_timer.sv
// Restartable cycle counter: done_c pulses on the PERIOD-th enabled cycle after load.
module lock_cycle_timer #(
    parameter int unsigned      CNT_W  = 32,
    parameter logic [CNT_W-1:0] PERIOD = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_c = en && !load && (cnt_q == PERIOD - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = done_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_digit_lock_ctrl.sv
// N-digit keypad lock with failed-attempt lockout and confirmed code change.
// Optional BLINK_EN macro blinks the entry cursor every BLINK_CYC cycles.
module multi_digit_lock_ctrl #(
    parameter int unsigned                   NUM_DIGITS  = 4,
    parameter int unsigned                   DIGIT_W     = 4,
    parameter int unsigned                   MAX_TRIES   = 3,
    parameter logic [31:0]                   LOCKOUT_CYC = 32'd500_000_000,
    parameter logic [31:0]                   BLINK_CYC   = 32'd50_000_000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ent,
    input  logic                             clr,
    input  logic                             change,
    input  logic [DIGIT_W-1:0]               sw,
    output logic [2:0]                       state_o,
    output logic                             locked_o,
    output logic                             lockout_o,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt_o,
    output logic                             pw_changed_o,
    output logic [5*NUM_DIGITS-1:0]          ssd_o
);
    import lock_pkg::*;

    localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned FC_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned SSD_W  = SYM_W * NUM_DIGITS;

    lock_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CODE_W-1:0] entry_q, entry_d;
    logic [CODE_W-1:0] new_q, new_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic              pw_chg_q, pw_chg_d;
    logic              locked_q, locked_d;
    logic              lockout_q, lockout_d;
    logic [SSD_W-1:0]  ssd_q, ssd_d;

    logic [CODE_W-1:0] entry_wr;
    logic [CODE_W-1:0] full_code;
    logic              last_digit;
    logic              lockout_done_c;
    logic              cursor_on;

    lock_cycle_timer #(.CNT_W(32), .PERIOD(LOCKOUT_CYC)) u_lockout_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state_q != ST_LOCKOUT),
        .en     (state_q == ST_LOCKOUT),
        .done_c (lockout_done_c)
    );

`ifdef BLINK_EN
    logic phase_q, phase_d;
    logic blink_load;
    logic blink_tick_c;

    // Phase restarts with the digit visible whenever the cursor moves or the state changes.
    assign blink_load = (state_d != state_q) || (idx_d != idx_q);

    lock_cycle_timer #(.CNT_W(32), .PERIOD(BLINK_CYC)) u_blink_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (blink_load),
        .en     (1'b1),
        .done_c (blink_tick_c)
    );

    always_comb begin
        phase_d = phase_q;
        if (blink_load) begin
            phase_d = 1'b0;
        end else if (blink_tick_c) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign cursor_on = ~phase_q;
`else
    assign cursor_on = 1'b1;
`endif

    // Entry buffer with the current digit written at the cursor; last digit compared straight from sw.
    always_comb begin
        entry_wr = entry_q;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (int'(idx_q) == p) begin
                entry_wr[CODE_W-1-p*DIGIT_W -: DIGIT_W] = sw;
            end
        end
        full_code  = {entry_q[CODE_W-1:DIGIT_W], sw};
        last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
    end

    // Next-state logic; clr outranks ent, which outranks change.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        entry_d  = entry_q;
        new_d    = new_q;
        code_d   = code_q;
        fail_d   = fail_q;
        pw_chg_d = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (!clr && ent) begin
                    state_d = ST_ENTER_L;
                    idx_d   = '0;
                    entry_d = '0;
                end
            end
            ST_ENTER_L, ST_ENTER_U, ST_NEW_PW, ST_CONFIRM_PW: begin
                if (clr) begin
                    idx_d   = '0;
                    entry_d = '0;
                    if (state_q == ST_NEW_PW || state_q == ST_CONFIRM_PW) begin
                        state_d = ST_NEW_PW;
                        new_d   = '0;
                    end
                end else if (ent && !last_digit) begin
                    entry_d = entry_wr;
                    idx_d   = idx_q + IDX_W'(1);
                end else if (ent) begin
                    idx_d   = '0;
                    entry_d = '0;
                    case (state_q)
                        ST_ENTER_L: begin
                            if (full_code == code_q) begin
                                state_d = ST_UNLOCKED;
                                fail_d  = '0;
                            end else begin
                                fail_d  = fail_q + FC_W'(1);
                                state_d = (fail_q + FC_W'(1) == FC_W'(MAX_TRIES)) ? ST_LOCKOUT : ST_LOCKED;
                            end
                        end
                        ST_ENTER_U: begin
                            state_d = (full_code == code_q) ? ST_LOCKED : ST_UNLOCKED;
                        end
                        ST_NEW_PW: begin
                            state_d = ST_CONFIRM_PW;
                            new_d   = full_code;
                        end
                        default: begin
                            state_d = ST_UNLOCKED;
                            new_d   = '0;
                            if (full_code == new_q) begin
                                code_d   = new_q;
                                pw_chg_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_UNLOCKED: begin
                if (!clr && ent) begin
                    state_d = ST_ENTER_U;
                    idx_d   = '0;
                    entry_d = '0;
                end else if (!clr && change) begin
                    state_d = ST_NEW_PW;
                    idx_d   = '0;
                    entry_d = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lockout_done_c) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_LOCKED;
                idx_d   = '0;
                entry_d = '0;
            end
        endcase

        locked_d  = !(state_d == ST_UNLOCKED || state_d == ST_NEW_PW || state_d == ST_CONFIRM_PW);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    // Display follows the registered state, so it trails state_o by one cycle.
    always_comb begin
        ssd_d = {NUM_DIGITS{SYM_BLANK}};
        if (state_q == ST_LOCKED || state_q == ST_UNLOCKED || state_q == ST_LOCKOUT) begin
            ssd_d[SSD_W-1 -: WORD_W] = status_word(state_q);
        end else begin
            for (int p = 0; p < NUM_DIGITS; p++) begin
                if (p < int'(idx_q)) begin
                    ssd_d[SSD_W-1-p*SYM_W -: SYM_W] =
                        (state_q == ST_ENTER_L || state_q == ST_ENTER_U) ? SYM_TIRE :
                        SYM_W'(entry_q[CODE_W-1-p*DIGIT_W -: DIGIT_W]);
                end else if (p == int'(idx_q) && cursor_on) begin
                    ssd_d[SSD_W-1-p*SYM_W -: SYM_W] = SYM_W'(sw);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOCKED;
            idx_q     <= '0;
            entry_q   <= '0;
            new_q     <= '0;
            code_q    <= RESET_CODE;
            fail_q    <= '0;
            pw_chg_q  <= 1'b0;
            locked_q  <= 1'b1;
            lockout_q <= 1'b0;
            ssd_q     <= {status_word(ST_LOCKED), {(NUM_DIGITS-4){SYM_BLANK}}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            entry_q   <= entry_d;
            new_q     <= new_d;
            code_q    <= code_d;
            fail_q    <= fail_d;
            pw_chg_q  <= pw_chg_d;
            locked_q  <= locked_d;
            lockout_q <= lockout_d;
            ssd_q     <= ssd_d;
        end
    end

    assign state_o      = state_q;
    assign locked_o     = locked_q;
    assign lockout_o    = lockout_q;
    assign fail_cnt_o   = fail_q;
    assign pw_changed_o = pw_chg_q;
    assign ssd_o        = ssd_q;

endmodule

// File: tb/tb_multi_digit_lock_ctrl.sv
// Bench for multi_digit_lock_ctrl: queue-based reference model checked every cycle plus literal pins.
module tb_multi_digit_lock_ctrl;
    import lock_pkg::*;

    localparam int N       = 4;
    localparam int TRIES   = 3;
    localparam int LOCKCYC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ent, clr, change;
    logic [3:0]  sw;
    logic [2:0]  state_o;
    logic        locked_o, lockout_o, pw_changed_o;
    logic [1:0]  fail_cnt_o;
    logic [19:0] ssd_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [19:0] W_CLSD = 20'b01100_10000_10001_01101;
    localparam logic [19:0] W_OPEN = 20'b10010_10011_01110_10100;

    multi_digit_lock_ctrl #(
        .NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3),
        .LOCKOUT_CYC(32'd20), .BLINK_CYC(32'd4), .RESET_CODE(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .ent(ent), .clr(clr), .change(change), .sw(sw),
        .state_o(state_o), .locked_o(locked_o), .lockout_o(lockout_o),
        .fail_cnt_o(fail_cnt_o), .pw_changed_o(pw_changed_o), .ssd_o(ssd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entered digits kept in a queue, lockout as a countdown.
    int   m_st;
    int   m_q[$];
    int   m_code[N];
    int   m_new[N];
    int   m_fail;
    int   m_left;
    bit   m_pw;
    logic [19:0] m_ssd;

    function automatic logic [19:0] disp(input int st, input int q[$], input logic [3:0] s);
        logic [4:0] sym[N];
        for (int p = 0; p < N; p++) sym[p] = SYM_BLANK;
        if (st == ST_LOCKED) begin
            sym[0] = SYM_C; sym[1] = SYM_L; sym[2] = SYM_S; sym[3] = SYM_D;
        end else if (st == ST_UNLOCKED) begin
            sym[0] = SYM_O; sym[1] = SYM_P; sym[2] = SYM_E; sym[3] = SYM_N;
        end else if (st == ST_LOCKOUT) begin
            for (int p = 0; p < N; p++) sym[p] = SYM_TIRE;
        end else begin
            for (int p = 0; p < N; p++) begin
                if (p < q.size())
                    sym[p] = (st == ST_ENTER_L || st == ST_ENTER_U) ? SYM_TIRE : 5'(q[p]);
                else if (p == q.size())
                    sym[p] = {1'b0, s};
            end
        end
        return {sym[0], sym[1], sym[2], sym[3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = ST_LOCKED; m_q.delete(); m_fail = 0; m_left = 0; m_pw = 0;
            for (int i = 0; i < N; i++) begin m_code[i] = 0; m_new[i] = 0; end
            m_ssd = W_CLSD;
        end else begin
            bit same;
            m_ssd = disp(m_st, m_q, sw);
            m_pw  = 0;
            case (m_st)
                ST_LOCKED: if (ent && !clr) begin m_st = ST_ENTER_L; m_q.delete(); end
                ST_UNLOCKED: begin
                    if (clr) ;
                    else if (ent)    begin m_st = ST_ENTER_U; m_q.delete(); end
                    else if (change) begin m_st = ST_NEW_PW;  m_q.delete(); end
                end
                ST_LOCKOUT: begin
                    m_left--;
                    if (m_left == 0) begin m_st = ST_LOCKED; m_fail = 0; end
                end
                default: begin
                    if (clr) begin
                        m_q.delete();
                        if (m_st == ST_CONFIRM_PW) m_st = ST_NEW_PW;
                    end else if (ent) begin
                        m_q.push_back(int'(sw));
                        if (m_q.size() == N) begin
                            same = 1;
                            for (int i = 0; i < N; i++)
                                if (m_q[i] != ((m_st == ST_CONFIRM_PW) ? m_new[i] : m_code[i])) same = 0;
                            case (m_st)
                                ST_ENTER_L: begin
                                    if (same) begin m_st = ST_UNLOCKED; m_fail = 0; end
                                    else begin
                                        m_fail++;
                                        if (m_fail == TRIES) begin m_st = ST_LOCKOUT; m_left = LOCKCYC; end
                                        else m_st = ST_LOCKED;
                                    end
                                end
                                ST_ENTER_U: m_st = same ? ST_LOCKED : ST_UNLOCKED;
                                ST_NEW_PW: begin
                                    for (int i = 0; i < N; i++) m_new[i] = m_q[i];
                                    m_st = ST_CONFIRM_PW;
                                end
                                default: begin
                                    if (same) begin
                                        for (int i = 0; i < N; i++) m_code[i] = m_new[i];
                                        m_pw = 1;
                                    end
                                    m_st = ST_UNLOCKED;
                                end
                            endcase
                            m_q.delete();
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_state",   32'(state_o),      32'(m_st));
            chk("model_locked",  32'(locked_o),     32'(!(m_st == ST_UNLOCKED || m_st == ST_NEW_PW || m_st == ST_CONFIRM_PW)));
            chk("model_lockout", 32'(lockout_o),    32'(m_st == ST_LOCKOUT));
            chk("model_fail",    32'(fail_cnt_o),   32'(m_fail));
            chk("model_pw",      32'(pw_changed_o), 32'(m_pw));
            chk("model_ssd",     32'(ssd_o),        32'(m_ssd));
        end
    end

    task automatic step(input logic e, input logic c, input logic ch, input logic [3:0] s);
        ent = e; clr = c; change = ch; sw = s;
        @(negedge clk);
        ent = 1'b0; clr = 1'b0; change = 1'b0;
    endtask

    task automatic digits4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        step(1, 0, 0, a); step(1, 0, 0, b); step(1, 0, 0, c); step(1, 0, 0, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; ent = 1'b0; clr = 1'b0; change = 1'b0; sw = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_state",   32'(state_o),      32'd0);
        chk("rst_locked",  32'(locked_o),     32'd1);
        chk("rst_lockout", 32'(lockout_o),    32'd0);
        chk("rst_fail",    32'(fail_cnt_o),   32'd0);
        chk("rst_pw",      32'(pw_changed_o), 32'd0);
        chk("rst_ssd",     32'(ssd_o),        32'(W_CLSD));
        rst = 1'b0;

        // Unlock with reset code 0000
        step(1, 0, 0, 0); digits4(0, 0, 0, 0);
        chk("unlock_state",  32'(state_o),  32'd2);
        chk("unlock_locked", 32'(locked_o), 32'd0);
        step(0, 0, 0, 0);
        chk("unlock_ssd", 32'(ssd_o), 32'(W_OPEN));

        // Bad confirm keeps code 0000
        step(0, 0, 1, 0);
        chk("newpw_state", 32'(state_o), 32'd4);
        digits4(1, 1, 1, 1);
        chk("confirm_state", 32'(state_o), 32'd5);
        digits4(1, 1, 1, 2);
        chk("badconf_state", 32'(state_o),      32'd2);
        chk("badconf_pw",    32'(pw_changed_o), 32'd0);
        step(1, 0, 0, 0); digits4(0, 0, 0, 0);
        chk("relock0000", 32'(state_o), 32'd0);

        // Three wrong attempts -> lockout for exactly 20 cycles
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0, 0); digits4(1, 2, 3, 4);
            if (k < 3) begin
                chk("wrong_fail",  32'(fail_cnt_o), 32'(k));
                chk("wrong_state", 32'(state_o),    32'd0);
            end
        end
        chk("lockout_state", 32'(state_o),   32'd6);
        chk("lockout_flag",  32'(lockout_o), 32'd1);
        n = 0;
        while (state_o == 3'd6 && n < 100) begin
            n++;
            step(n[0], n[1], n[2], 4'(n));
        end
        chk("lockout_len",   32'(n),          32'd20);
        chk("lockout_exit",  32'(state_o),    32'd0);
        chk("lockout_fail0", 32'(fail_cnt_o), 32'd0);

        // Change code to 5678
        step(1, 0, 0, 0); digits4(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 5); step(1, 0, 0, 6); step(0, 0, 0, 9);
        chk("newpw_ssd", 32'(ssd_o), 32'(20'b00101_00110_01001_11111));
        step(1, 0, 0, 7); step(1, 0, 0, 8);
        chk("confirm_enter", 32'(state_o), 32'd5);
        digits4(5, 6, 7, 8);
        chk("chg_pw1",   32'(pw_changed_o), 32'd1);
        chk("chg_state", 32'(state_o),      32'd2);
        step(0, 0, 0, 0);
        chk("chg_pw0", 32'(pw_changed_o), 32'd0);
        step(1, 0, 0, 0); digits4(5, 6, 7, 8);
        chk("relock5678", 32'(state_o), 32'd0);
        step(1, 0, 0, 0); digits4(0, 0, 0, 0);
        chk("old_code_fails", 32'(state_o),    32'd0);
        chk("old_code_fail1", 32'(fail_cnt_o), 32'd1);
        step(1, 0, 0, 0); digits4(5, 6, 7, 8);
        chk("new_code_opens", 32'(state_o),    32'd2);
        chk("new_code_fail0", 32'(fail_cnt_o), 32'd0);
        step(1, 0, 0, 0); digits4(5, 6, 7, 8);

        // clr after two digits, then clr+ent in the same cycle
        step(1, 0, 0, 0); step(1, 0, 0, 3); step(1, 0, 0, 4); step(0, 1, 0, 7);
        chk("clr_state",   32'(state_o), 32'd1);
        chk("clr_ssd_old", 32'(ssd_o),   32'(20'b10101_10101_00111_11111));
        step(0, 0, 0, 7);
        chk("clr_ssd_new", 32'(ssd_o),   32'(20'b00111_11111_11111_11111));
        step(1, 0, 0, 3); step(1, 1, 0, 5); digits4(5, 6, 7, 8);
        chk("clr_ent_prio", 32'(state_o), 32'd2);

        // Reset during lockout countdown
        step(1, 0, 0, 0); digits4(5, 6, 7, 8);
        for (int k = 0; k < 3; k++) begin step(1, 0, 0, 0); digits4(1, 2, 3, 4); end
        repeat (5) step(0, 0, 0, 0);
        chk("pre_rst_lockout", 32'(state_o), 32'd6);
        rst = 1'b1;
        #1;
        chk("mid_rst_state",   32'(state_o),    32'd0);
        chk("mid_rst_fail",    32'(fail_cnt_o), 32'd0);
        chk("mid_rst_lockout", 32'(lockout_o),  32'd0);
        chk("mid_rst_ssd",     32'(ssd_o),      32'(W_CLSD));
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0); digits4(0, 0, 0, 0);
        chk("rst_code_restored", 32'(state_o), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
